// File: rtl/fw_cfg_chain_ctrl_if.sv
// rtl/fw_cfg_chain_ctrl_if.sv - word source, readback sink and config-chain pins of fw_cfg_chain_ctrl
interface fw_cfg_chain_ctrl_if #(
    parameter int ADDR_W = 5
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic              rb_we;
    logic [ADDR_W-1:0] rb_addr;
    logic [31:0]       rb_data;
    logic              fw_config_clk;
    logic              fw_config_in;
    logic              fw_config_load;
    logic              fw_config_out;

    modport master (
        output rd_req, rd_addr, rb_we, rb_addr, rb_data,
        output fw_config_clk, fw_config_in, fw_config_load,
        input  rd_data, fw_config_out
    );

    modport slave (
        input  rd_req, rd_addr, rb_we, rb_addr, rb_data,
        input  fw_config_clk, fw_config_in, fw_config_load,
        output rd_data, fw_config_out
    );
endinterface

// File: rtl/fw_cfg_chain_ctrl.sv
// rtl/fw_cfg_chain_ctrl.sv - config shift-chain sequencer; FW_CFG_CHAIN_READBACK_EN adds fw_config_out capture
module fw_cfg_chain_ctrl #(
    parameter int CNT_W  = 10,
    parameter int DIV_W  = 8,
    parameter int ADDR_W = CNT_W - 5
) (
    input  logic                fw_clk,
    input  logic                fw_rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                status_clear,
    input  logic [CNT_W-1:0]    bit_count,
    input  logic [DIV_W-1:0]    clk_div,
    input  logic                load_en,
    fw_cfg_chain_ctrl_if.master bus,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [CNT_W-1:0]    bits_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_LOW, S_HIGH, S_LOAD, S_FIN
    } state_t;

    localparam logic [DIV_W:0]    H_ONE    = (DIV_W+1)'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              load_q, load_d;
    logic [DIV_W:0]    hcnt, hcnt_d;
    logic [4:0]        bit_pos, bit_pos_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_req_q, rd_req_d;
    logic              cfg_clk_q, cfg_clk_d;
    logic              cfg_in_q, cfg_in_d;
    logic              cfg_load_q, cfg_load_d;
    logic              busy_d, done_d, error_d;
    logic [CNT_W-1:0]  bits_done_d;
    logic              start_ok;
    logic [DIV_W:0]    h_full;
    logic              abort_now, high_first, high_exit, last_bit;

    assign h_full     = {1'b0, div_q};
    assign abort_now  = abort && (state != S_IDLE);
    assign high_first = (state == S_HIGH) && (hcnt == h_full);
    assign high_exit  = (state == S_HIGH) && (hcnt == '0);
    assign last_bit   = ((bits_done + CNT_ONE) == cnt_q);

    always_ff @(posedge fw_clk or negedge fw_rst_n) begin
        if (!fw_rst_n) state <= S_IDLE;
        else           state <= state_d;
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt_q;
        div_d       = div_q;
        load_d      = load_q;
        hcnt_d      = hcnt;
        bit_pos_d   = bit_pos;
        word_d      = word_q;
        rd_addr_d   = rd_addr_q;
        rd_req_d    = 1'b0;
        cfg_clk_d   = cfg_clk_q;
        cfg_in_d    = cfg_in_q;
        cfg_load_d  = cfg_load_q;
        busy_d      = busy;
        bits_done_d = bits_done;
        done_d      = done & ~status_clear;
        error_d     = error & ~status_clear;
        start_ok    = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    if (bit_count == '0) begin
                        error_d = 1'b1;
                    end else begin
                        start_ok    = 1'b1;
                        state_d     = S_FETCH;
                        busy_d      = 1'b1;
                        rd_req_d    = 1'b1;
                        rd_addr_d   = '0;
                        bits_done_d = '0;
                        cnt_d       = bit_count;
                        div_d       = clk_div;
                        load_d      = load_en;
                    end
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                word_d    = bus.rd_data;
                bit_pos_d = 5'd31;
                cfg_in_d  = bus.rd_data[31];
                hcnt_d    = h_full;
                state_d   = S_LOW;
            end
            S_LOW: begin
                if (hcnt == '0) begin
                    state_d   = S_HIGH;
                    cfg_clk_d = 1'b1;
                    hcnt_d    = h_full;
                end else begin
                    hcnt_d = hcnt - H_ONE;
                end
            end
            S_HIGH: begin
                if (high_exit) begin
                    cfg_clk_d   = 1'b0;
                    bits_done_d = bits_done + CNT_ONE;
                    if (last_bit) begin
                        if (load_q) begin
                            state_d    = S_LOAD;
                            cfg_load_d = 1'b0;
                            hcnt_d     = {div_q, 1'b1};
                        end else begin
                            state_d  = S_FIN;
                            cfg_in_d = 1'b0;
                        end
                    end else if (bit_pos == 5'd0) begin
                        state_d   = S_FETCH;
                        rd_req_d  = 1'b1;
                        rd_addr_d = rd_addr_q + ADDR_ONE;
                    end else begin
                        state_d   = S_LOW;
                        bit_pos_d = bit_pos - 5'd1;
                        cfg_in_d  = word_q[bit_pos - 5'd1];
                        hcnt_d    = h_full;
                    end
                end else begin
                    hcnt_d = hcnt - H_ONE;
                end
            end
            S_LOAD: begin
                if (hcnt == '0) begin
                    state_d    = S_FIN;
                    cfg_load_d = 1'b1;
                    cfg_in_d   = 1'b0;
                end else begin
                    hcnt_d = hcnt - H_ONE;
                end
            end
            S_FIN: begin
                state_d   = S_IDLE;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                rd_addr_d = '0;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides whatever the state decode chose, including a FIN completion.
        if (abort_now) begin
            state_d     = S_IDLE;
            cfg_clk_d   = 1'b0;
            cfg_load_d  = 1'b1;
            cfg_in_d    = 1'b0;
            rd_req_d    = 1'b0;
            rd_addr_d   = '0;
            busy_d      = 1'b0;
            error_d     = 1'b1;
            done_d      = done & ~status_clear;
            bits_done_d = bits_done;
        end
    end

    always_ff @(posedge fw_clk or negedge fw_rst_n) begin
        if (!fw_rst_n) begin
            cnt_q      <= '0;
            div_q      <= '0;
            load_q     <= 1'b0;
            hcnt       <= '0;
            bit_pos    <= '0;
            word_q     <= '0;
            rd_addr_q  <= '0;
            rd_req_q   <= 1'b0;
            cfg_clk_q  <= 1'b0;
            cfg_in_q   <= 1'b0;
            cfg_load_q <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            bits_done  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            load_q     <= load_d;
            hcnt       <= hcnt_d;
            bit_pos    <= bit_pos_d;
            word_q     <= word_d;
            rd_addr_q  <= rd_addr_d;
            rd_req_q   <= rd_req_d;
            cfg_clk_q  <= cfg_clk_d;
            cfg_in_q   <= cfg_in_d;
            cfg_load_q <= cfg_load_d;
            busy       <= busy_d;
            done       <= done_d;
            error      <= error_d;
            bits_done  <= bits_done_d;
        end
    end

    assign bus.rd_req         = rd_req_q;
    assign bus.rd_addr        = rd_addr_q;
    assign bus.fw_config_clk  = cfg_clk_q;
    assign bus.fw_config_in   = cfg_in_q;
    assign bus.fw_config_load = cfg_load_q;

`ifdef FW_CFG_CHAIN_READBACK_EN
    logic [31:0]       rb_word, rb_word_s;
    logic              rb_we_q;
    logic [ADDR_W-1:0] rb_addr_q;
    logic [31:0]       rb_data_q;

    // With H=1 the sample and the HIGH exit share an edge, so the write uses the merged word.
    always_comb begin
        rb_word_s = rb_word;
        if (high_first) rb_word_s[bit_pos] = bus.fw_config_out;
    end

    always_ff @(posedge fw_clk or negedge fw_rst_n) begin
        if (!fw_rst_n) begin
            rb_word   <= '0;
            rb_we_q   <= 1'b0;
            rb_addr_q <= '0;
            rb_data_q <= '0;
        end else begin
            rb_we_q <= 1'b0;
            if (start_ok) begin
                rb_word <= '0;
            end else if (high_exit && !abort_now && (last_bit || bit_pos == 5'd0)) begin
                rb_we_q   <= 1'b1;
                rb_addr_q <= rd_addr_q;
                rb_data_q <= rb_word_s;
                rb_word   <= '0;
            end else if (high_first) begin
                rb_word <= rb_word_s;
            end
        end
    end

    assign bus.rb_we   = rb_we_q;
    assign bus.rb_addr = rb_addr_q;
    assign bus.rb_data = rb_data_q;
`else
    assign bus.rb_we   = 1'b0;
    assign bus.rb_addr = '0;
    assign bus.rb_data = '0;
    wire unused_rb = &{1'b0, bus.fw_config_out, start_ok, high_first};
`endif

endmodule

// File: tb/tb_fw_cfg_chain_ctrl.sv
// tb/tb_fw_cfg_chain_ctrl.sv - self-checking bench for fw_cfg_chain_ctrl
module tb_fw_cfg_chain_ctrl;
    localparam int CNT_W  = 10;
    localparam int DIV_W  = 8;
    localparam int ADDR_W = 5;
    localparam int LIMIT  = 4000;

    logic              fw_clk = 1'b0;
    logic              fw_rst_n = 1'b0;
    logic              start = 1'b0, abort = 1'b0, status_clear = 1'b0, load_en = 1'b0;
    logic [CNT_W-1:0]  bit_count = '0;
    logic [DIV_W-1:0]  clk_div = '0;
    logic              busy, done, error;
    logic [CNT_W-1:0]  bits_done;

    fw_cfg_chain_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    fw_cfg_chain_ctrl #(.CNT_W(CNT_W), .DIV_W(DIV_W), .ADDR_W(ADDR_W)) dut (
        .fw_clk(fw_clk), .fw_rst_n(fw_rst_n), .start(start), .abort(abort),
        .status_clear(status_clear), .bit_count(bit_count), .clk_div(clk_div),
        .load_en(load_en), .bus(bus), .busy(busy), .done(done), .error(error),
        .bits_done(bits_done)
    );

    always #5 fw_clk = ~fw_clk;

    logic [31:0] mem [0:31];
    always @(posedge fw_clk) if (bus.rd_req) bus.rd_data <= mem[bus.rd_addr];

    // Two-stage chain: the return lags the input by one chain bit.
    logic s0 = 1'b0, s1 = 1'b0, chain_clr = 1'b0;
    always @(posedge bus.fw_config_clk or posedge chain_clr) begin
        if (chain_clr) begin s0 <= 1'b0; s1 <= 1'b0; end
        else begin s0 <= bus.fw_config_in; s1 <= s0; end
    end
    assign bus.fw_config_out = s1;

    int   tests = 0, fails = 0;
    int   rises, cyc_hi, hi_run, hi_min, hi_max, rdreq_cnt, load_lo;
    bit   prev_clk;
    bit   in_bits[$];
    int   rb_addrs[$];
    logic [31:0] rb_datas[$];

    always @(negedge fw_clk) begin
        if (bus.fw_config_clk) begin
            cyc_hi++;
            hi_run++;
            if (!prev_clk) begin rises++; in_bits.push_back(bus.fw_config_in); end
        end else if (prev_clk) begin
            if (hi_run < hi_min) hi_min = hi_run;
            if (hi_run > hi_max) hi_max = hi_run;
            hi_run = 0;
        end
        if (bus.rd_req) rdreq_cnt++;
        if (!bus.fw_config_load) load_lo++;
        if (bus.rb_we) begin rb_addrs.push_back(int'(bus.rb_addr)); rb_datas.push_back(bus.rb_data); end
        prev_clk = bus.fw_config_clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mon_reset();
        rises = 0; cyc_hi = 0; hi_run = 0; hi_min = 1 << 30; hi_max = 0;
        rdreq_cnt = 0; load_lo = 0; prev_clk = 1'b0;
        in_bits.delete(); rb_addrs.delete(); rb_datas.delete();
        chain_clr = 1'b1; #1 chain_clr = 1'b0;
    endtask

    task automatic clear_status();
        @(posedge fw_clk); #1 status_clear = 1'b1;
        @(posedge fw_clk); #1 status_clear = 1'b0;
    endtask

    function automatic logic stream_bit(input int idx);
        logic [31:0] wd;
        wd = mem[idx / 32];
        return wd[31 - (idx % 32)];
    endfunction

    function automatic logic [31:0] exp_rb(input int wi, input int n);
        logic [31:0] r;
        r = '0;
        for (int j = 0; j < 32; j++) begin
            int k;
            k = 32 * wi + j;
            if (k < n) r[31 - j] = (k == 0) ? 1'b0 : stream_bit(k - 1);
        end
        return r;
    endfunction

    task automatic do_run(input string tag, input int n, input int div, input bit le,
                          input bit poke, input bit clr_fin, output int cnt);
        int h, w, exp_len, errs;
        h = div + 1;
        w = (n + 31) / 32;
        exp_len = 2 * w + 2 * h * n + (le ? 2 * h : 0) + 1;
        if (!clr_fin) clear_status();
        mon_reset();
        @(posedge fw_clk); #1;
        bit_count = CNT_W'(n); clk_div = DIV_W'(div); load_en = le; start = 1'b1;
        @(posedge fw_clk); #1;
        start = 1'b0; bit_count = CNT_W'($urandom); clk_div = DIV_W'($urandom); load_en = ~le;
        check({tag, "_busy_t1"}, 32'(busy), 1);
        check({tag, "_rdreq_t1"}, 32'(bus.rd_req), 1);
        cnt = 0;
        while (cnt < LIMIT) begin
            if (cnt == 2) begin
                check({tag, "_first_in"}, 32'(bus.fw_config_in), 32'(stream_bit(0)));
                check({tag, "_first_low"}, 32'(bus.fw_config_clk), 0);
            end
            start = poke && (cnt == 3);
            if (poke && cnt == 3) begin bit_count = CNT_W'(3); clk_div = '0; end
            status_clear = clr_fin && (cnt == exp_len - 1);
            @(posedge fw_clk); #1;
            cnt++;
            if (!busy) break;
        end
        start = 1'b0; status_clear = 1'b0;
        check({tag, "_len"}, cnt, exp_len);
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_error"}, 32'(error), 0);
        check({tag, "_bits_done"}, 32'(bits_done), n);
        check({tag, "_rises"}, rises, n);
        errs = 0;
        foreach (in_bits[i]) if (i < n && in_bits[i] != stream_bit(i)) errs++;
        check({tag, "_bit_errs"}, errs, 0);
        check({tag, "_hi_cycles"}, cyc_hi, h * n);
        check({tag, "_hi_min"}, hi_min, h);
        check({tag, "_hi_max"}, hi_max, h);
        check({tag, "_rdreq"}, rdreq_cnt, w);
        check({tag, "_load_lo"}, load_lo, le ? 2 * h : 0);
        check({tag, "_idle_pins"}, {29'd0, bus.fw_config_clk, bus.fw_config_in, bus.fw_config_load}, 1);
        check({tag, "_rd_addr"}, 32'(bus.rd_addr), 0);
`ifdef FW_CFG_CHAIN_READBACK_EN
        check({tag, "_rb_cnt"}, rb_addrs.size(), w);
        for (int i = 0; i < w && i < rb_addrs.size(); i++) begin
            check({tag, "_rb_addr"}, rb_addrs[i], i);
            check({tag, "_rb_data"}, rb_datas[i], exp_rb(i, n));
        end
`else
        check({tag, "_rb_cnt"}, rb_addrs.size(), 0);
`endif
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, r;
        logic [7:0] seq;
        bit prev;

        foreach (mem[i]) mem[i] = $urandom;
        mon_reset();
        #12;
        check("rst_pins", {28'd0, bus.fw_config_clk, bus.fw_config_in, bus.fw_config_load, bus.rd_req}, 2);
        check("rst_status", {29'd0, busy, done, error}, 0);
        check("rst_bits_done", 32'(bits_done), 0);
        check("rst_rd_addr", 32'(bus.rd_addr), 0);
        check("rst_rb", {bus.rb_we, 26'd0, bus.rb_addr}, 0);
        check("rst_rb_data", bus.rb_data, 0);
        @(posedge fw_clk); #1 fw_rst_n = 1'b1;

        // Basic run
        mem[0] = 32'hA500_0000;
        do_run("basic", 8, 0, 1'b1, 1'b0, 1'b0, cnt);
        check("basic_done_t22", cnt, 21);
        seq = '0;
        foreach (in_bits[i]) if (i < 8) seq[7 - i] = in_bits[i];
        check("basic_seq", 32'(seq), 32'hA5);

        // Multi-word with loopback readback
        mem[0] = 32'hDEAD_BEEF; mem[1] = 32'h1200_0000;
        do_run("multi", 40, 2, 1'b0, 1'b0, 1'b0, cnt);

        // Randomised runs against the model
        for (int i = 0; i < 4; i++) begin
            foreach (mem[j]) mem[j] = $urandom;
            do_run($sformatf("rand%0d", i), $urandom_range(1, 90), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 1'b0, 1'b0, cnt);
        end

        // start while busy is ignored; status_clear at FIN loses to done
        do_run("busy_start", 8, 1, 1'b0, 1'b1, 1'b0, cnt);
        do_run("clr_fin", 5, 0, 1'b1, 1'b0, 1'b1, cnt);

        // Zero length
        clear_status(); mon_reset();
        @(posedge fw_clk); #1 bit_count = '0; start = 1'b1;
        @(posedge fw_clk); #1 start = 1'b0;
        check("zero_error", 32'(error), 1);
        check("zero_busy", 32'(busy), 0);
        repeat (3) @(posedge fw_clk);
        #1;
        check("zero_activity", rdreq_cnt + rises, 0);

        // start and abort together
        clear_status(); mon_reset();
        @(posedge fw_clk); #1 bit_count = CNT_W'(8); clk_div = '0; start = 1'b1; abort = 1'b1;
        @(posedge fw_clk); #1 start = 1'b0; abort = 1'b0;
        repeat (3) @(posedge fw_clk);
        #1;
        check("coll_busy", 32'(busy), 0);
        check("coll_error", 32'(error), 0);
        check("coll_activity", rdreq_cnt + rises, 0);

        // Abort at the HIGH exit of bit 5 (last bit of a partial word)
        clear_status(); mon_reset();
        mem[0] = $urandom;
        @(posedge fw_clk); #1 bit_count = CNT_W'(6); clk_div = DIV_W'(1); load_en = 1'b1; start = 1'b1;
        @(posedge fw_clk); #1 start = 1'b0;
        r = 0; cnt = 0; prev = 1'b0;
        while (r < 6 && cnt < 200) begin
            @(posedge fw_clk); #1;
            cnt++;
            if (bus.fw_config_clk && !prev) r++;
            prev = bus.fw_config_clk;
        end
        check("abort_reach_bit5", r, 6);
        @(posedge fw_clk); #1 abort = 1'b1;
        @(posedge fw_clk); #1 abort = 1'b0;
        check("abort_pins", {29'd0, bus.fw_config_clk, bus.fw_config_in, bus.fw_config_load}, 1);
        check("abort_status", {29'd0, busy, done, error}, 1);
        check("abort_bits_done", 32'(bits_done), 5);
        repeat (4) @(posedge fw_clk);
        #1;
        check("abort_no_rb", rb_addrs.size(), 0);
        check("abort_no_more_clk", rises, 6);

        // Reset during LOAD
        clear_status(); mon_reset();
        @(posedge fw_clk); #1 bit_count = CNT_W'(4); clk_div = DIV_W'(1); load_en = 1'b1; start = 1'b1;
        @(posedge fw_clk); #1 start = 1'b0;
        cnt = 0;
        while (bus.fw_config_load !== 1'b0 && cnt < 200) begin @(posedge fw_clk); #1; cnt++; end
        check("rstrun_in_load", 32'(bus.fw_config_load), 0);
        #2 fw_rst_n = 1'b0;
        #1;
        check("rstrun_pins", {28'd0, bus.fw_config_clk, bus.fw_config_in, bus.fw_config_load, bus.rd_req}, 2);
        check("rstrun_status", {29'd0, busy, done, error}, 0);
        check("rstrun_bits_done", 32'(bits_done), 0);
        @(posedge fw_clk); #1 fw_rst_n = 1'b1;
        foreach (mem[j]) mem[j] = $urandom;
        do_run("after_rst", 33, 0, 1'b1, 1'b0, 1'b0, cnt);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fw_cfg_chain_ctrl.md
# fw_cfg_chain_ctrl

Sequencer for the DUT configuration shift chain. It fetches configuration words from a word-addressed source and serialises them MSB-first onto `fw_config_in` under a programmable `fw_config_clk`. It then pulses `fw_config_load` and optionally captures `fw_config_out` into a readback buffer. It sits between the firmware register/array storage and the `fw_config_*` DUT pins of an IP block, and replaces their static tie-offs.

## Interface
- `CNT_W`, 10, width of bit count; at most 2^CNT_W−1 bits per run
- `DIV_W`, 8, width of the half-period divider
- `ADDR_W`, CNT_W−5, word address width
- `fw_clk`  in  1  FW clock
- `fw_rst_n`  in  1  FW reset; asynchronous, active-low
- `start`  in  1  one-cycle run request; ignored while `busy`
- `abort`  in  1  one-cycle abort request
- `status_clear`  in  1  clears sticky `done` and `error`
- `bit_count`  in  CNT_W  bits to shift; sampled on accepted `start`
- `clk_div`  in  DIV_W  half-period H = `clk_div`+1 fw_clk cycles; sampled on `start`
- `load_en`  in  1  issue load pulse after shift; sampled on `start`
- `rd_req`  out  1  word fetch strobe
- `rd_addr`  out  ADDR_W  word address, 0-based
- `rd_data`  in  32  word data; valid in the cycle after `rd_req`
- `rb_we`  out  1  readback word write strobe
- `rb_addr`  out  ADDR_W  readback word address
- `rb_data`  out  32  readback word
- `fw_config_clk`  out  1  chain shift clock
- `fw_config_in`  out  1  chain serial data
- `fw_config_load`  out  1  chain load; idle high, active-low pulse
- `fw_config_out`  in  1  chain serial return
- `busy`  out  1  run in progress
- `done`  out  1  sticky, run completed
- `error`  out  1  sticky, abort or zero-length start
- `bits_done`  out  CNT_W  bits shifted in the current or last run

## Operation
- States: IDLE, FETCH, WAIT, LOW, HIGH, LOAD, FIN.
- **IDLE:**
  - Accepted `start` with `bit_count`≠0 → FETCH, `busy`=1, `bits_done`=0.
  - `bit_count`=0 → stay in IDLE and set `error`.
- **FETCH:** `rd_req`=1 for one cycle with the current `rd_addr` → WAIT.
- **WAIT:** latch `rd_data` into the shift word → LOW.
- **LOW:**
  - `fw_config_clk`=0.
  - `fw_config_in` = current bit, taken from the word MSB first.
  - Hold for H cycles → HIGH.
- **HIGH:**
  - `fw_config_clk`=1 for H cycles.
  - `fw_config_out` is sampled at the end of the first HIGH cycle.
  - `bits_done` increments at HIGH exit.
- **Exit from HIGH:**
  - If it was the last bit: `load_en` → LOAD, otherwise → FIN.
  - Else if it was bit 0 of the word: `rd_addr`+1 → FETCH.
  - Otherwise → LOW with the next bit.
- **LOAD:** `fw_config_load`=0 for 2H cycles with `fw_config_clk`=0 → FIN.
- **FIN:**
  - Set `done`, `busy`=0, `rd_addr`=0 → IDLE.
  - `fw_config_in` returns to 0.
- **Partial last word:** only its top (`bit_count` mod 32) bits are shifted.
- **Abort:**
  - Takes effect from any non-IDLE state → IDLE on the next cycle.
  - Forces `fw_config_clk`=0, `fw_config_load`=1, `fw_config_in`=0.
  - Sets `error`; `done` is not set; `bits_done` is held.
- **Simultaneous events:**
  - `start` and `abort` together: abort wins and `start` is dropped.
  - `status_clear` in the same cycle as a set condition: the set wins.
- **Reset values:**
  - `fw_config_clk`=0, `fw_config_in`=0, `fw_config_load`=1.
  - `rd_req`=0, `rd_addr`=0, `rb_we`=0, `rb_addr`=0, `rb_data`=0.
  - `busy`=0, `done`=0, `error`=0, `bits_done`=0, state IDLE.
- Reset asserted mid-run returns all outputs to these values immediately; no load pulse is issued.

## Timing
- Accepted `start` at edge T:
  - `busy` and `rd_req` are high from T+1.
  - First LOW phase begins at T+3.
- Each word costs 2 fetch cycles, during which `fw_config_clk` is held low.
- Run length from start to `done`, with N bits and W = ceil(N/32) words: 2W + 2H·N + (`load_en` ? 2H : 0) + 1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `FW_CFG_CHAIN_READBACK_EN`.
- **Defined:**
  - Sampled `fw_config_out` bits are packed MSB-first into a readback word.
  - `rb_we` pulses for one cycle when 32 bits have been collected, with `rb_addr` = word index.
  - On the last bit, `rb_we` pulses at HIGH exit even for a partial word, with the unfilled low bits zero.
  - An abort suppresses the partial-word write.
- **Undefined:** `rb_we`, `rb_addr` and `rb_data` are tied to 0 and no capture logic is built.

## Test plan
- **Basic run:** `bit_count`=8, `clk_div`=0, `load_en`=1, word0=0xA5000000 → `fw_config_in` sequence 1,0,1,0,0,1,0,1; 8 clock pulses, each 1 high/1 low; one 2-cycle low on `fw_config_load`; `done` at T+22.
- **Multi-word and readback:**
  - Setup: `bit_count`=40, `clk_div`=2, readback enabled, words 0xDEADBEEF and 0x12000000, loop `fw_config_out` to `fw_config_in` delayed by one chain bit.
  - Required: two `rd_req`, `rb_we` at `rb_addr` 0 and 1, and `bits_done`=40.
- **Zero length:** `start` with `bit_count`=0 → `error`=1; `busy`, `rd_req` and `fw_config_clk` stay 0.
- **Abort mid-shift:**
  - Stimulus: `abort` issued during bit 5 HIGH.
  - Required: next cycle `fw_config_clk`=0, `fw_config_load`=1, `busy`=0, `error`=1, `bits_done`=5, and no `rb_we`.
- **Collisions:**
  - `start` and `abort` in the same cycle → no activity.
  - `start` while `busy` → ignored and the run is unchanged.
  - `status_clear` coinciding with FIN → `done`=1.
- **Reset mid-run:** drop `fw_rst_n` during LOAD → `fw_config_load`=1 and all outputs at reset values asynchronously; a `start` after reset runs normally.
